// File: rtl/muldiv_hilo_sequencer.sv
// Iterative 8x8 multiply / restoring divide that commits Hi/Lo through the shared RF write port.
// Optional two's-complement operation: define SIGNED_MULDIV_EN.
module muldiv_hilo_sequencer #(
    parameter int         WIDTH   = 8,
    parameter logic [3:0] HI_ADDR = 4'd8,
    parameter logic [3:0] LO_ADDR = 4'd9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    input  logic             core_reg_write,
    input  logic [3:0]       core_write_reg,
    input  logic [WIDTH-1:0] core_write_data,
    output logic             rf_reg_write,
    output logic [3:0]       rf_write_reg,
    output logic [WIDTH-1:0] rf_write_data
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, WR_HI, WR_LO} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] res_hi, res_lo;

`ifdef SIGNED_MULDIV_EN
    logic               neg_ab_q, neg_ab_d, neg_a_q, neg_a_d;
    logic [2*WIDTH-1:0] prod_s;

    // Iterate on magnitudes; signs are reapplied on the way out.
    assign mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    always_comb begin
        prod_s = neg_ab_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (op_q) begin
            res_hi = neg_a_q ? -hi_q : hi_q;
            res_lo = neg_ab_q ? -lo_q : lo_q;
        end else begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
        end
    end
`else
    assign mag_a  = operand_a;
    assign mag_b  = operand_b;
    assign res_hi = hi_q;
    assign res_lo = lo_q;
`endif

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef SIGNED_MULDIV_EN
        neg_ab_d = neg_ab_q;
        neg_a_d  = neg_a_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    a_d   = mag_a;
                    b_d   = mag_b;
                    cnt_d = '0;
                    if (op && operand_b == '0) begin
                        hi_d    = operand_a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = WR_HI;
`ifdef SIGNED_MULDIV_EN
                        neg_ab_d = 1'b0;
                        neg_a_d  = 1'b0;
`endif
                    end else begin
                        hi_d    = '0;
                        lo_d    = op ? mag_a : mag_b;
                        dbz_d   = 1'b0;
                        state_d = CALC;
`ifdef SIGNED_MULDIV_EN
                        neg_ab_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        neg_a_d  = operand_a[WIDTH-1];
`endif
                    end
                end
            end
            CALC: begin
                if (op_q) begin
                    hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                if (!core_reg_write) state_d = WR_LO;
            end
            WR_LO: begin
                if (!core_reg_write) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Core write-back always wins the port.
    always_comb begin
        rf_reg_write  = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        if (core_reg_write) begin
            rf_reg_write  = 1'b1;
            rf_write_reg  = core_write_reg;
            rf_write_data = core_write_data;
        end else if (state_q == WR_HI) begin
            rf_reg_write  = 1'b1;
            rf_write_reg  = HI_ADDR;
            rf_write_data = res_hi;
        end else if (state_q == WR_LO) begin
            rf_reg_write  = 1'b1;
            rf_write_reg  = LO_ADDR;
            rf_write_data = res_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            neg_ab_q <= 1'b0;
            neg_a_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef SIGNED_MULDIV_EN
            neg_ab_q <= neg_ab_d;
            neg_a_q  <= neg_a_d;
`endif
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign div_by_zero = done_q & dbz_q;

endmodule

// File: doc/muldiv_hilo_sequencer.md
Name: muldiv_hilo_sequencer

Overview:
Multi-cycle multiply/divide sequencer for the 8-bit core. It computes 8x8 products and quotient/remainder iteratively, then commits the results to the Hi (reg 8) and Lo (reg 9) entries of the register file through its single write port. It also arbitrates that write port between itself and the core's normal write-back path; the core always has priority. It sits between the core write-back stage and the register file write port.

Parameters:
WIDTH, 8, operand/register data width.
HI_ADDR, 4'd8, register file address of Hi.
LO_ADDR, 4'd9, register file address of Lo.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request an operation; sampled only when not busy
op  input  1  0 = multiply, 1 = divide
operand_a  input  WIDTH  multiplicand / dividend
operand_b  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress; core must not read Hi/Lo or issue start
done  output  1  one-cycle pulse after the Lo write commits
div_by_zero  output  1  valid with done; divide with operand_b == 0
core_reg_write  input  1  core write-back request
core_write_reg  input  4  core write-back address
core_write_data  input  WIDTH  core write-back data
rf_reg_write  output  1  to register file reg_write
rf_write_reg  output  4  to register file write_reg
rf_write_data  output  WIDTH  to register file write_data

Behaviour:
- States: IDLE, CALC, WR_HI, WR_LO.
- Reset values: state IDLE; busy, done and div_by_zero = 0; internal accumulators and counter = 0. Reset does not modify register file contents.
- IDLE, start=1: latch op and operands; busy=1 from the next cycle.
  - op=1 with operand_b==0: go to WR_HI (CALC skipped).
  - Otherwise: go to CALC with counter = 0.
- start while busy: ignored, no effect on any state.
- CALC: exactly WIDTH cycles, one iteration per cycle; counter wraps to 0 on exit; then WR_HI.
- Multiply: unsigned shift-add producing a 2*WIDTH product. Hi = product[15:8], Lo = product[7:0].
- Divide: restoring, one quotient bit per cycle. Lo = quotient, Hi = remainder.
- Divide by zero: Hi = operand_a, Lo = 8'hFF, div_by_zero = 1 with done.
- WR_HI: request a write of HI_ADDR. Advance to WR_LO only in a cycle where core_reg_write==0 (the write commits that edge). WR_LO is the same for LO_ADDR, then IDLE.
- done: registered pulse in the cycle after the Lo write commits; busy = 0 in that same cycle, and start is accepted in that cycle.
- Latency (start high in cycle 0, no contention): CALC cycles 1-8, Hi write cycle 9, Lo write cycle 10, done cycle 11. Divide by zero: Hi write cycle 1, Lo write cycle 2, done cycle 3. Each contended cycle adds 1.
- Write-port mux (combinational):
  - core_reg_write=1: rf_* = core_*.
  - Else, in WR_HI/WR_LO: rf_reg_write=1 with sequencer address and data.
  - Else: rf_reg_write=0, and rf_write_reg/rf_write_data are 0.
- Core writes to reg 8/9 while busy are passed through; the sequencer's later write overwrites them.
- Reset mid-operation: next cycle state IDLE, busy=0, no further Hi/Lo writes; partial results are discarded.

Optional Feature:
SIGNED_MULDIV_EN
- Defined: operands are two's complement. The block computes on magnitudes, then negates the result; this adds no cycles.
  - Product sign = a_sign XOR b_sign.
  - Quotient sign = a_sign XOR b_sign; remainder takes the sign of the dividend.
  - Divide by zero behaves as in the unsigned case.
- Undefined: all operations are unsigned; no sign logic is synthesized.

Test Plan:
- mul 13*11, start cycle 0 -> reg9=8'h8F written cycle 10, reg8=8'h00 cycle 9, done=1 cycle 11 only, busy high cycles 1-10.
- div 200/7 -> Lo=8'h1C, Hi=8'h04, div_by_zero=0 with done; also mul 255*255 -> Hi=8'hFE, Lo=8'h01.
- div 8'h55/0 -> Hi=8'h55 cycle 1, Lo=8'hFF cycle 2, done and div_by_zero=1 cycle 3.
- mul 3*5 with core_reg_write=1 (reg 3 <= 8'hAA) held cycles 9-10 -> reg3=8'hAA, Hi commits cycle 11, Lo cycle 12, done cycle 13; start pulses in cycles 4 and 12 are ignored.
- reset asserted in cycle 5 of a multiply -> busy=0 cycle 6, reg8/reg9 unchanged, no rf_reg_write; new start 2*2 -> Lo=8'h04.
- With SIGNED_MULDIV_EN: mul 8'hFD*5 -> Hi=8'hFF, Lo=8'hF1; div -7/2 -> Lo=8'hFD, Hi=8'hFF. Without it: mul 253*5 -> Hi=8'h04, Lo=8'hF1.
